// File: rtl/stage_sequencer.sv
// Single-clock IF/ID/EX/MEM/WB sequencer. Issues one-cycle stage enables,
// stretches FETCH/MEM on memory handshakes, and provides run/step/halt control.
module stage_sequencer #(
  parameter int WAIT_MAX = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_run,
  input  logic        i_step,
  input  logic        i_imem_ready,
  input  logic        i_dmem_ready,
  input  logic        i_mem_access,
  output logic        o_en_if,
  output logic        o_en_id,
  output logic        o_en_ex,
  output logic        o_en_mem,
  output logic        o_en_wb,
  output logic        o_imem_req,
  output logic        o_dmem_req,
  output logic        o_halted,
  output logic        o_timeout,
  output logic [31:0] o_instr_cnt
);

  typedef enum logic [2:0] {
    S_HALT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } state_t;

  state_t      r_state;
  logic        r_step_mode;
  logic        r_timeout;
  logic [7:0]  r_wait_cnt;
  logic [31:0] r_instr_cnt;

  logic w_wait_expired;
  logic w_mem_done;

  assign w_wait_expired = (r_wait_cnt == 8'(WAIT_MAX - 1));
  // A non-memory instruction passes MEM without a data handshake.
  assign w_mem_done     = !i_mem_access || i_dmem_ready;

  always_comb begin
    o_halted   = (r_state == S_HALT);
    o_imem_req = (r_state == S_FETCH);
    o_dmem_req = (r_state == S_MEM) && i_mem_access;
    o_en_if    = (r_state == S_FETCH) && i_imem_ready;
    o_en_id    = (r_state == S_DECODE);
    o_en_ex    = (r_state == S_EXEC);
    o_en_mem   = (r_state == S_MEM) && w_mem_done;
    o_en_wb    = (r_state == S_WB);
  end

  assign o_timeout   = r_timeout;
  assign o_instr_cnt = r_instr_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_HALT;
      r_step_mode <= 1'b0;
      r_timeout   <= 1'b0;
      r_wait_cnt  <= 8'd0;
      r_instr_cnt <= 32'd0;
    end else begin
      case (r_state)
        S_HALT: begin
          r_wait_cnt <= 8'd0;
          if (!r_timeout && (i_run || i_step)) begin
            r_state     <= S_FETCH;
            r_step_mode <= i_step && !i_run;
          end
        end
        S_FETCH: begin
          if (i_imem_ready) begin
            r_state    <= S_DECODE;
            r_wait_cnt <= 8'd0;
          end else if (w_wait_expired) begin
            r_state     <= S_HALT;
            r_timeout   <= 1'b1;
            r_step_mode <= 1'b0;
            r_wait_cnt  <= 8'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC:   r_state <= S_MEM;
        S_MEM: begin
          if (w_mem_done) begin
            r_state    <= S_WB;
            r_wait_cnt <= 8'd0;
          end else if (w_wait_expired) begin
            r_state     <= S_HALT;
            r_timeout   <= 1'b1;
            r_step_mode <= 1'b0;
            r_wait_cnt  <= 8'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_WB: begin
          r_instr_cnt <= r_instr_cnt + 32'd1;
          r_wait_cnt  <= 8'd0;
          if (i_run && !r_step_mode) begin
            r_state <= S_FETCH;
          end else begin
            r_state     <= S_HALT;
            r_step_mode <= 1'b0;
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: a per-cycle vector table plus hand-written
// timeout, counter-wrap and reset-during-wait sequences.
module tb_stage_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, step, imem_rdy, dmem_rdy, mem_acc;
  logic        en_if, en_id, en_ex, en_mem, en_wb;
  logic        imem_req, dmem_req, halted, timeout;
  logic [31:0] instr_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stage_sequencer #(.WAIT_MAX(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_run(run), .i_step(step),
    .i_imem_ready(imem_rdy), .i_dmem_ready(dmem_rdy), .i_mem_access(mem_acc),
    .o_en_if(en_if), .o_en_id(en_id), .o_en_ex(en_ex), .o_en_mem(en_mem),
    .o_en_wb(en_wb), .o_imem_req(imem_req), .o_dmem_req(dmem_req),
    .o_halted(halted), .o_timeout(timeout), .o_instr_cnt(instr_cnt)
  );

  // {halted, imem_req, dmem_req, en_if, en_id, en_ex, en_mem, en_wb}
  logic [7:0] outs;
  assign outs = {halted, imem_req, dmem_req, en_if, en_id, en_ex, en_mem, en_wb};

  localparam logic [7:0] H  = 8'b1000_0000;
  localparam logic [7:0] F  = 8'b0100_0000;
  localparam logic [7:0] FI = 8'b0101_0000;
  localparam logic [7:0] D  = 8'b0000_1000;
  localparam logic [7:0] E  = 8'b0000_0100;
  localparam logic [7:0] M  = 8'b0000_0010;
  localparam logic [7:0] MW = 8'b0010_0000;
  localparam logic [7:0] MD = 8'b0010_0010;
  localparam logic [7:0] W  = 8'b0000_0001;

  typedef struct {
    logic        run, step, ir, dr, ma;
    logic [7:0]  outs;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic s, input logic ir, input logic dr,
                     input logic ma, input logic [7:0] o, input logic [31:0] c);
    vec_t v;
    v.run = r; v.step = s; v.ir = ir; v.dr = dr; v.ma = ma; v.outs = o; v.cnt = c;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic ir, input logic dr,
                       input logic ma);
    run = r; step = s; imem_rdy = ir; dmem_rdy = dr; mem_acc = ma;
  endtask

  initial begin
    int wb_seen;
    int spent;

    // Free run, four zero-wait instructions back to back.
    add(1,0,1,1,0, H, 0);
    for (int k = 0; k < 4; k++) begin
      add(1,0,1,1,0, FI, k); add(1,0,1,1,0, D, k); add(1,0,1,1,0, E, k);
      add(1,0,1,1,0, M,  k); add(1,0,1,1,0, W, k);
    end
    // Three imem wait cycles: 4 request cycles, 8-cycle instruction.
    add(1,0,0,1,0, F, 4); add(1,0,0,1,0, F, 4); add(1,0,0,1,0, F, 4);
    add(1,0,1,1,0, FI, 4); add(1,0,1,1,0, D, 4); add(1,0,1,1,0, E, 4);
    add(1,0,1,1,0, M, 4);  add(1,0,1,1,0, W, 4);
    // Load/store with 2 dmem wait cycles; run drops mid-instruction, step ignored.
    add(1,0,1,1,0, FI, 5); add(0,0,1,1,0, D, 5); add(0,1,1,1,0, E, 5);
    add(0,0,1,0,1, MW, 5); add(0,0,1,0,1, MW, 5); add(0,0,1,1,1, MD, 5);
    add(0,0,1,1,0, W, 5);  add(0,0,1,1,0, H, 6);
    // Single step, with a second step pulse mid-instruction ignored.
    add(0,1,1,1,0, H, 6);  add(0,0,1,1,0, FI, 6); add(0,1,1,1,0, D, 6);
    add(0,0,1,1,0, E, 6);  add(0,0,1,1,0, M, 6);  add(0,0,1,1,0, W, 6);
    add(0,0,1,1,0, H, 7);  add(0,0,1,1,0, H, 7);
    // Run and step together act as run: no halt after the first WB.
    add(1,1,1,1,0, H, 7);  add(1,0,1,1,0, FI, 7); add(1,0,1,1,0, D, 7);
    add(1,0,1,1,0, E, 7);  add(1,0,1,1,0, M, 7);  add(1,0,1,1,0, W, 7);
    add(0,0,1,1,0, FI, 8); add(0,0,1,1,0, D, 8);  add(0,0,1,1,0, E, 8);
    add(0,0,1,1,0, M, 8);  add(0,0,1,1,0, W, 8);  add(0,0,1,1,0, H, 9);

    // Reset state.
    drive(0,0,1,1,0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_outs", 32'(outs), 32'(H));
    chk("reset_timeout", 32'(timeout), 32'd0);
    chk("reset_cnt", instr_cnt, 32'd0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].run, tbl[i].step, tbl[i].ir, tbl[i].dr, tbl[i].ma);
      #1;
      chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(tbl[i].outs));
      chk($sformatf("vec%0d_cnt", i), instr_cnt, tbl[i].cnt);
    end

    // Timeout: imem never ready; 16 request cycles, then sticky halt.
    @(negedge clk);
    drive(1,0,0,1,0);
    #1;
    chk("to_start", 32'(outs), 32'(H));
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1;
      chk($sformatf("to_wait%0d", i), 32'(outs), 32'(F));
      chk($sformatf("to_flag%0d", i), 32'(timeout), 32'd0);
    end
    @(negedge clk); #1;
    chk("to_halted", 32'(outs), 32'(H));
    chk("to_flag_set", 32'(timeout), 32'd1);
    drive(1,1,1,1,0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("to_sticky%0d", i), 32'(outs), 32'(H));
      chk($sformatf("to_stickyflag%0d", i), 32'(timeout), 32'd1);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(0,0,1,1,0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("to_clear", 32'(timeout), 32'd0);
    chk("to_clear_outs", 32'(outs), 32'(H));
    chk("to_clear_cnt", instr_cnt, 32'd0);

    // Counter wrap: preload all-ones while halted, then retire one instruction.
    @(negedge clk);
    force dut.r_instr_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_instr_cnt;
    #1;
    chk("wrap_preload", instr_cnt, 32'hFFFF_FFFF);
    drive(0,1,1,1,0);
    @(negedge clk);
    drive(0,0,1,1,0);
    wb_seen = 0;
    spent = 0;
    while (spent < 20) begin
      #1;
      if (en_wb) wb_seen++;
      if (halted && wb_seen > 0) break;
      @(negedge clk);
      spent++;
    end
    chk("wrap_bounded", 32'(spent < 20), 32'd1);
    chk("wrap_wb_count", wb_seen, 32'd1);
    chk("wrap_cnt", instr_cnt, 32'd0);

    // Reset during a MEM wait returns straight to HALT.
    @(negedge clk);
    drive(1,0,1,0,1);
    #1;
    chk("mrst_start", 32'(outs), 32'(H));
    repeat (5) @(negedge clk);
    #1;
    chk("mrst_waiting", 32'(outs), 32'(MW));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(0,0,1,0,1);
    #1;
    chk("mrst_outs", 32'(outs), 32'(H));
    chk("mrst_timeout", 32'(timeout), 32'd0);
    chk("mrst_cnt", instr_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
